// File: rtl/axis_video_frame_arbiter.sv
// Frame-granular round-robin arbiter that shares one AXI-Stream video output
// between several AXI-Stream video inputs. A source is granted on its
// start-of-frame beat and keeps the output until the last TLAST of its frame.
// Pixel data is passed through combinationally; grant and line counting are
// registered.
module axis_video_frame_arbiter #(
  parameter int NUM_SOURCES    = 2,
  parameter int PIXEL_PER_CLK  = 1,
  parameter int BITS_PER_PIXEL = 32,
  parameter int IMAGE_HEIGHT   = 540
) (
  input  logic                                                 clk,
  input  logic                                                 rst,
  input  logic                                                 enable,
  input  logic [NUM_SOURCES*BITS_PER_PIXEL*PIXEL_PER_CLK-1:0]  s_axis_video_in_tdata,
  input  logic [NUM_SOURCES-1:0]                               s_axis_video_in_tvalid,
  input  logic [NUM_SOURCES-1:0]                               s_axis_video_in_tlast,
  input  logic [NUM_SOURCES-1:0]                               s_axis_video_in_tuser,
  output logic [NUM_SOURCES-1:0]                               s_axis_video_in_tready,
  output logic [BITS_PER_PIXEL*PIXEL_PER_CLK-1:0]              m_axis_video_out_tdata,
  output logic                                                 m_axis_video_out_tvalid,
  output logic                                                 m_axis_video_out_tlast,
  output logic                                                 m_axis_video_out_tuser,
  input  logic                                                 m_axis_video_out_tready,
  output logic [((NUM_SOURCES > 1) ? $clog2(NUM_SOURCES) : 1)-1:0] grant_idx,
  output logic                                                 busy,
  output logic                                                 frame_done,
  output logic                                                 sof_error
);

  localparam int DW = BITS_PER_PIXEL * PIXEL_PER_CLK;
  localparam int IW = (NUM_SOURCES > 1) ? $clog2(NUM_SOURCES) : 1;
  localparam int LW = $clog2(IMAGE_HEIGHT + 1);

  localparam logic [0:0] ST_IDLE = 1'b0;
  localparam logic [0:0] ST_PASS = 1'b1;

  localparam logic [IW-1:0] LAST_SRC  = IW'(NUM_SOURCES - 1);
  localparam logic [LW-1:0] LAST_LINE = LW'(IMAGE_HEIGHT - 1);

  logic [0:0]    stateQ, stateD;
  logic [IW-1:0] grantQ, grantD;
  logic [IW-1:0] lastGrantQ, lastGrantD;
  logic [LW-1:0] lineCntQ, lineCntD;
  logic          firstBeatQ, firstBeatD;
  logic          frameDoneQ, frameDoneD;
  logic          sofErrorQ, sofErrorD;

  logic [DW-1:0]          srcData [NUM_SOURCES];
  logic [NUM_SOURCES-1:0] candidates;
  logic [IW:0]            scanIdx;
  logic                   winnerFound;
  logic [IW-1:0]          winnerIdx;
  logic [DW-1:0]          selData;
  logic                   selValid;
  logic                   selLast;
  logic                   selUser;
  logic                   masterXfer;

  // Split the packed input data bus into one slice per source
  always_comb begin
    for (int i = 0; i < NUM_SOURCES; i++) begin
      srcData[i] = s_axis_video_in_tdata[i*DW +: DW];
    end
  end

  // Signals of the currently granted source
  always_comb begin
    selData    = srcData[grantQ];
    selValid   = s_axis_video_in_tvalid[grantQ];
    selLast    = s_axis_video_in_tlast[grantQ];
    selUser    = s_axis_video_in_tuser[grantQ];
    candidates = s_axis_video_in_tvalid & s_axis_video_in_tuser;
    masterXfer = (stateQ == ST_PASS) && selValid && m_axis_video_out_tready;
  end

  // Round-robin scan starting just after the last granted source
  always_comb begin
    winnerFound = 1'b0;
    winnerIdx   = '0;
    scanIdx     = '0;
    for (int k = 1; k <= NUM_SOURCES; k++) begin
      scanIdx = {1'b0, lastGrantQ} + (IW+1)'(k);
      if (scanIdx >= (IW+1)'(NUM_SOURCES)) begin
        scanIdx = scanIdx - (IW+1)'(NUM_SOURCES);
      end
      if (!winnerFound && candidates[scanIdx[IW-1:0]]) begin
        winnerFound = 1'b1;
        winnerIdx   = scanIdx[IW-1:0];
      end
    end
  end

  // Output steering: passthrough when granted, flush non-SOF beats when idle
  always_comb begin
    s_axis_video_in_tready  = '0;
    m_axis_video_out_tdata  = '0;
    m_axis_video_out_tvalid = 1'b0;
    m_axis_video_out_tlast  = 1'b0;
    m_axis_video_out_tuser  = 1'b0;
    if (!rst) begin
      if (stateQ == ST_PASS) begin
        m_axis_video_out_tdata         = selData;
        m_axis_video_out_tvalid        = selValid;
        m_axis_video_out_tlast         = selLast;
        m_axis_video_out_tuser         = selUser;
        s_axis_video_in_tready[grantQ] = m_axis_video_out_tready;
      end else begin
        s_axis_video_in_tready = s_axis_video_in_tvalid & ~s_axis_video_in_tuser;
      end
    end
  end

  // Next-state logic for grant, line counting and status pulses
  always_comb begin
    stateD     = stateQ;
    grantD     = grantQ;
    lastGrantD = lastGrantQ;
    lineCntD   = lineCntQ;
    firstBeatD = firstBeatQ;
    frameDoneD = 1'b0;
    sofErrorD  = 1'b0;
    if (stateQ == ST_IDLE) begin
      if (enable && winnerFound) begin
        stateD     = ST_PASS;
        grantD     = winnerIdx;
        lastGrantD = winnerIdx;
        lineCntD   = '0;
        firstBeatD = 1'b1;
      end
    end else if (masterXfer) begin
      firstBeatD = 1'b0;
      if (selUser && !firstBeatQ) begin
        sofErrorD = 1'b1;
        lineCntD  = '0;
      end else if (selLast) begin
        if (lineCntQ == LAST_LINE) begin
          lineCntD   = '0;
          stateD     = ST_IDLE;
          frameDoneD = 1'b1;
        end else begin
          lineCntD = lineCntQ + LW'(1);
        end
      end
    end
  end

  // State registers with synchronous reset
  always_ff @(posedge clk) begin
    if (rst) begin
      stateQ     <= ST_IDLE;
      grantQ     <= '0;
      lastGrantQ <= LAST_SRC;
      lineCntQ   <= '0;
      firstBeatQ <= 1'b0;
      frameDoneQ <= 1'b0;
      sofErrorQ  <= 1'b0;
    end else begin
      stateQ     <= stateD;
      grantQ     <= grantD;
      lastGrantQ <= lastGrantD;
      lineCntQ   <= lineCntD;
      firstBeatQ <= firstBeatD;
      frameDoneQ <= frameDoneD;
      sofErrorQ  <= sofErrorD;
    end
  end

  // Registered status outputs
  always_comb begin
    grant_idx  = grantQ;
    busy       = (stateQ == ST_PASS);
    frame_done = frameDoneQ;
    sof_error  = sofErrorQ;
  end

endmodule

// File: tb/tb_axis_video_frame_arbiter.sv
// Self-checking bench for axis_video_frame_arbiter: two sources, four-line
// frames of eight 16-bit pixels, with a frame-level reference model compared
// against the DUT every cycle plus directed literal expectations.
module tb_axis_video_frame_arbiter;

  localparam int NSRC   = 2;
  localparam int HEIGHT = 4;
  localparam int WIDTH  = 8;

  logic        clk = 1'b0;
  logic        rst;
  logic        enable;
  logic [31:0] sData;
  logic [1:0]  sValid;
  logic [1:0]  sLast;
  logic [1:0]  sUser;
  logic [1:0]  sReady;
  logic [15:0] mData;
  logic        mValid;
  logic        mLast;
  logic        mUser;
  logic        mReady;
  logic [0:0]  grantIdx;
  logic        busy;
  logic        frameDone;
  logic        sofError;

  int checks = 0;
  int errors = 0;

  logic [17:0] q0[$];
  logic [17:0] q1[$];
  logic [15:0] outLog[$];
  int doneCount = 0;
  int sofCount = 0;
  int sofAtLog = -1;
  bit sinkRandom = 1'b0;

  int mdlOwner = -1;
  int mdlLast = NSRC - 1;
  int mdlGrant = 0;
  int mdlLines = 0;
  bit mdlFirst = 1'b0;
  bit mdlFd = 1'b0;
  bit mdlSe = 1'b0;

  axis_video_frame_arbiter #(
    .NUM_SOURCES(NSRC),
    .PIXEL_PER_CLK(1),
    .BITS_PER_PIXEL(16),
    .IMAGE_HEIGHT(HEIGHT)
  ) dut (
    .clk(clk),
    .rst(rst),
    .enable(enable),
    .s_axis_video_in_tdata(sData),
    .s_axis_video_in_tvalid(sValid),
    .s_axis_video_in_tlast(sLast),
    .s_axis_video_in_tuser(sUser),
    .s_axis_video_in_tready(sReady),
    .m_axis_video_out_tdata(mData),
    .m_axis_video_out_tvalid(mValid),
    .m_axis_video_out_tlast(mLast),
    .m_axis_video_out_tuser(mUser),
    .m_axis_video_out_tready(mReady),
    .grant_idx(grantIdx),
    .busy(busy),
    .frame_done(frameDone),
    .sof_error(sofError)
  );

  // Free-running clock
  always #5 clk = ~clk;

  task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
    checks++;
    if (actual !== expected) begin
      errors++;
      $display("[TB] FAIL %s actual=%0h expected=%0h at %0t", name, actual, expected, $time);
    end
  endtask

  task automatic pushBeat(input int src, input logic [17:0] beat);
    if (src == 0) q0.push_back(beat);
    else q1.push_back(beat);
  endtask

  // Frame of `lines` lines; data = {src, frame, line, pixel}, optional extra SOF at sofLine
  task automatic pushFrame(input int src, input int frameId, input int lines, input int sofLine);
    logic [17:0] beat;
    for (int l = 0; l < lines; l++) begin
      for (int p = 0; p < WIDTH; p++) begin
        beat[17]    = (p == 0) && (l == 0 || l == sofLine);
        beat[16]    = (p == WIDTH - 1);
        beat[15:0]  = {4'(src), 4'(frameId), 4'(l), 4'(p)};
        pushBeat(src, beat);
      end
    end
  endtask

  task automatic driveSources();
    sValid = 2'b00; sLast = 2'b00; sUser = 2'b00; sData = '0;
    if (q0.size() > 0) begin
      sValid[0] = 1'b1; sUser[0] = q0[0][17]; sLast[0] = q0[0][16]; sData[15:0] = q0[0][15:0];
    end
    if (q1.size() > 0) begin
      sValid[1] = 1'b1; sUser[1] = q1[0][17]; sLast[1] = q1[0][16]; sData[31:16] = q1[0][15:0];
    end
  endtask

  // One clock cycle: present source heads, pop beats accepted at the edge
  task automatic applyStimulus();
    bit x0;
    bit x1;
    driveSources();
    @(negedge clk);
    x0 = sValid[0] && sReady[0];
    x1 = sValid[1] && sReady[1];
    @(posedge clk);
    #1;
    if (x0) void'(q0.pop_front());
    if (x1) void'(q1.pop_front());
    if (sinkRandom) mReady = 1'($urandom_range(0, 1));
    driveSources();
  endtask

  task automatic runCycles(input int n);
    for (int i = 0; i < n; i++) applyStimulus();
  endtask

  // Run until the chosen queues drain, bounded by maxCycles
  task automatic runUntilEmpty(input bit bothQueues, input int maxCycles, input string name);
    int n = 0;
    while (((q0.size() > 0) || (bothQueues && q1.size() > 0)) && n < maxCycles) begin
      applyStimulus();
      n++;
    end
    checks++;
    if ((q0.size() > 0) || (bothQueues && q1.size() > 0)) begin
      errors++;
      $display("[TB] FAIL %s timeout: q0=%0d q1=%0d beats left, required 0", name, q0.size(), q1.size());
    end
  endtask

  task automatic applyReset();
    rst = 1'b1;
    runCycles(2);
    rst = 1'b0;
    outLog.delete();
    doneCount = 0;
    sofCount = 0;
    sofAtLog = -1;
  endtask

  // Reference model and per-cycle compare, evaluated mid-cycle on stable inputs
  initial begin
    logic [1:0]  expReady;
    logic        expValid;
    logic [15:0] expData;
    logic        expLast;
    logic        expUser;
    bit          found;
    int          c;
    forever begin
      @(negedge clk);
      if (sofError === 1'b1 && sofAtLog < 0) sofAtLog = outLog.size();
      if (frameDone === 1'b1) doneCount++;
      if (sofError === 1'b1) sofCount++;
      if (mValid === 1'b1 && mReady === 1'b1) outLog.push_back(mData);

      expReady = 2'b00; expValid = 1'b0; expData = '0; expLast = 1'b0; expUser = 1'b0;
      if (!rst) begin
        if (mdlOwner < 0) begin
          expReady = sValid & ~sUser;
        end else begin
          expValid = sValid[mdlOwner];
          expData  = sData[mdlOwner*16 +: 16];
          expLast  = sLast[mdlOwner];
          expUser  = sUser[mdlOwner];
          expReady[mdlOwner] = mReady;
        end
      end
      checkOutput("s_tready", 32'(sReady), 32'(expReady));
      checkOutput("m_tvalid", 32'(mValid), 32'(expValid));
      checkOutput("m_tdata", 32'(mData), 32'(expData));
      checkOutput("m_tlast", 32'(mLast), 32'(expLast));
      checkOutput("m_tuser", 32'(mUser), 32'(expUser));
      checkOutput("busy", 32'(busy), 32'(mdlOwner >= 0));
      checkOutput("grant_idx", 32'(grantIdx), 32'(mdlGrant));
      checkOutput("frame_done", 32'(frameDone), 32'(mdlFd));
      checkOutput("sof_error", 32'(sofError), 32'(mdlSe));

      if (rst) begin
        mdlOwner = -1; mdlLast = NSRC - 1; mdlGrant = 0; mdlLines = 0;
        mdlFirst = 1'b0; mdlFd = 1'b0; mdlSe = 1'b0;
      end else begin
        mdlFd = 1'b0;
        mdlSe = 1'b0;
        if (mdlOwner < 0) begin
          found = 1'b0;
          if (enable) begin
            for (int k = 1; k <= NSRC; k++) begin
              c = (mdlLast + k) % NSRC;
              if (!found && sValid[c] && sUser[c]) begin
                found = 1'b1;
                mdlOwner = c; mdlGrant = c; mdlLast = c; mdlLines = 0; mdlFirst = 1'b1;
              end
            end
          end
        end else if (sValid[mdlOwner] && mReady) begin
          if (sUser[mdlOwner] && !mdlFirst) begin
            mdlSe = 1'b1;
            mdlLines = 0;
          end else if (sLast[mdlOwner]) begin
            mdlLines++;
            if (mdlLines == HEIGHT) begin
              mdlLines = 0;
              mdlOwner = -1;
              mdlFd = 1'b1;
            end
          end
          mdlFirst = 1'b0;
        end
      end
    end
  end

  // Directed scenarios
  initial begin
    int junkSeen;
    rst = 1'b1; enable = 1'b1; mReady = 1'b1;
    sValid = 2'b00; sLast = 2'b00; sUser = 2'b00; sData = '0;

    // Round-robin across two sources, then back to source 0
    applyReset();
    checkOutput("reset busy", 32'(busy), 32'd0);
    checkOutput("reset grant_idx", 32'(grantIdx), 32'd0);
    pushFrame(0, 0, HEIGHT, -1);
    pushFrame(0, 1, HEIGHT, -1);
    pushFrame(1, 0, HEIGHT, -1);
    applyStimulus();
    checkOutput("first grant busy", 32'(busy), 32'd1);
    checkOutput("first grant m_tuser", 32'(mUser), 32'd1);
    checkOutput("first grant m_tdata", 32'(mData), 32'h0000);
    runUntilEmpty(1'b1, 400, "round robin");
    runCycles(3);
    checkOutput("rr beat count", outLog.size(), 32'd96);
    checkOutput("rr beat 31", 32'(outLog[31]), 32'h0037);
    checkOutput("rr beat 32", 32'(outLog[32]), 32'h1000);
    checkOutput("rr beat 64", 32'(outLog[64]), 32'h0100);
    checkOutput("rr frame_done count", doneCount, 32'd3);
    checkOutput("rr final grant", 32'(grantIdx), 32'd0);

    // Non-SOF beats while idle are flushed, then the frame is forwarded
    applyReset();
    for (int j = 0; j < 3; j++) pushBeat(1, {2'b00, 16'(16'hF000 + j)});
    pushFrame(1, 2, HEIGHT, -1);
    runUntilEmpty(1'b1, 200, "flush");
    runCycles(2);
    junkSeen = 0;
    foreach (outLog[i]) if (outLog[i][15:12] == 4'hF) junkSeen++;
    checkOutput("flush junk forwarded", junkSeen, 32'd0);
    checkOutput("flush beat count", outLog.size(), 32'd32);
    checkOutput("flush first beat", 32'(outLog[0]), 32'h1200);
    checkOutput("flush grant", 32'(grantIdx), 32'd1);

    // Random sink backpressure keeps both sequences intact
    applyReset();
    pushFrame(0, 3, HEIGHT, -1);
    pushFrame(1, 3, HEIGHT, -1);
    sinkRandom = 1'b1;
    runUntilEmpty(1'b1, 1000, "backpressure");
    sinkRandom = 1'b0;
    mReady = 1'b1;
    runCycles(2);
    checkOutput("bp beat count", outLog.size(), 32'd64);
    for (int k = 0; k < 64; k++) begin
      if (k < outLog.size()) begin
        if (k < 32) checkOutput("bp sequence", 32'(outLog[k]), 32'({4'd0, 4'd3, 4'(k / 8), 4'(k % 8)}));
        else checkOutput("bp sequence", 32'(outLog[k]), 32'({4'd1, 4'd3, 4'((k - 32) / 8), 4'((k - 32) % 8)}));
      end
    end

    // Mid-frame SOF on line 2 restarts the line count
    applyReset();
    pushFrame(0, 4, HEIGHT + 2, 2);
    runUntilEmpty(1'b1, 200, "sof error");
    runCycles(2);
    checkOutput("sof_error count", sofCount, 32'd1);
    checkOutput("sof_error position", sofAtLog, 32'd17);
    checkOutput("sof frame_done count", doneCount, 32'd1);
    checkOutput("sof beat count", outLog.size(), 32'd48);

    // enable gates only new grants
    enable = 1'b0;
    applyReset();
    pushFrame(0, 5, HEIGHT, -1);
    pushFrame(1, 5, HEIGHT, -1);
    runCycles(5);
    checkOutput("disabled busy", 32'(busy), 32'd0);
    enable = 1'b1;
    applyStimulus();
    checkOutput("enabled busy", 32'(busy), 32'd1);
    checkOutput("enabled grant", 32'(grantIdx), 32'd0);
    runCycles(10);
    enable = 1'b0;
    runUntilEmpty(1'b0, 200, "enable drop");
    runCycles(3);
    checkOutput("enable drop frame_done", doneCount, 32'd1);
    checkOutput("enable drop busy", 32'(busy), 32'd0);
    checkOutput("enable drop src1 held", q1.size(), 32'd32);
    enable = 1'b1;
    runUntilEmpty(1'b1, 200, "enable resume");
    runCycles(2);
    checkOutput("enable resume frame_done", doneCount, 32'd2);

    // Reset mid-frame aborts; remainder is flushed and the next SOF wins
    applyReset();
    pushFrame(0, 6, HEIGHT, -1);
    for (int n = 0; n < 100 && outLog.size() < 18; n++) applyStimulus();
    checkOutput("reset mid-frame reached line 2", 32'(outLog.size() >= 18), 32'd1);
    rst = 1'b1;
    applyStimulus();
    checkOutput("mid reset busy", 32'(busy), 32'd0);
    checkOutput("mid reset grant", 32'(grantIdx), 32'd0);
    checkOutput("mid reset m_tvalid", 32'(mValid), 32'd0);
    checkOutput("mid reset s_tready", 32'(sReady), 32'd0);
    rst = 1'b0;
    outLog.delete();
    doneCount = 0;
    pushFrame(0, 7, HEIGHT, -1);
    runUntilEmpty(1'b1, 200, "after reset");
    runCycles(2);
    checkOutput("after reset beat count", outLog.size(), 32'd32);
    checkOutput("after reset first beat", 32'(outLog[0]), 32'h0700);
    checkOutput("after reset frame_done", doneCount, 32'd1);
    checkOutput("after reset grant", 32'(grantIdx), 32'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
